// File: rtl/ex_pkg.sv
// Shared definitions for the RV32I execute stage:
// opcodes, funct3 codes and the internal ALU operation enum.
package ex_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B,
        ALU_LINK
    } alu_op_e;

endpackage

// File: rtl/ex_stage_alu_core.sv
// Purely combinational RV32I ALU.
// Shift amount is b[4:0]; LINK returns a + 4.
module alu_core
    import ex_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         alu_op,
    output logic [XLEN-1:0] y
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    // Select the result for the decoded operation
    always_comb begin
        y = '0;
        unique case (alu_op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << shamt;
            ALU_SLT:    y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:   y = {31'd0, a < b};
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> shamt;
            ALU_SRA:    y = $unsigned($signed(a) >>> shamt);
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_PASS_B: y = b;
            ALU_LINK:   y = a + 32'd4;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: decode, ALU, branch compare,
// and the EX/MEM output registers.
module ex_stage
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic [XLEN-1:0] alu_result,
    output logic            branch_taken,
    output logic [XLEN-1:0] alu_result_q,
    output logic            branch_taken_q,
    output logic            out_valid
);

    alu_op_e         alu_op;
    logic            op_known;
    logic [XLEN-1:0] alu_y;
    logic            f7_alt;
    logic            eq;
    logic            lt;
    logic            ltu;
    logic            unused_f7;

    assign f7_alt    = funct7[5];
    assign unused_f7 = ^{funct7[6], funct7[4:0]};

    // Map funct3 (+ f7 bit 5 where relevant) to an ALU op
    function automatic alu_op_e f3_op(
        input logic [2:0] f3,
        input logic       alt_sub,
        input logic       alt_sra
    );
        alu_op_e op;
        op = ALU_ADD;
        unique case (f3)
            F3_ADD:  op = alt_sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SRL:  op = alt_sra ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Opcode decode; unknown opcodes force the result to zero
    always_comb begin
        alu_op   = ALU_ADD;
        op_known = 1'b1;
        unique case (opcode)
            OP_R:      alu_op = f3_op(funct3, f7_alt, f7_alt);
            OP_IMM:    alu_op = f3_op(funct3, 1'b0, f7_alt);
            OP_LUI:    alu_op = ALU_PASS_B;
            OP_AUIPC:  alu_op = ALU_ADD;
            OP_LOAD:   alu_op = ALU_ADD;
            OP_STORE:  alu_op = ALU_ADD;
            OP_BRANCH: alu_op = ALU_SUB;
            OP_JAL:    alu_op = ALU_LINK;
            OP_JALR:   alu_op = ALU_LINK;
            default:   op_known = 1'b0;
        endcase
    end

    alu_core u_alu (
        .a      (operand1),
        .b      (operand2),
        .alu_op (alu_op),
        .y      (alu_y)
    );

    assign alu_result = op_known ? alu_y : '0;

    assign eq  = (operand1 == operand2);
    assign lt  = ($signed(operand1) < $signed(operand2));
    assign ltu = (operand1 < operand2);

    // Branch decision; only BRANCH opcodes can be taken
    always_comb begin
        branch_taken = 1'b0;
        if (opcode == OP_BRANCH) begin
            unique case (funct3)
                F3_BEQ:  branch_taken = eq;
                F3_BNE:  branch_taken = !eq;
                F3_BLT:  branch_taken = lt;
                F3_BGE:  branch_taken = !lt;
                F3_BLTU: branch_taken = ltu;
                F3_BGEU: branch_taken = !ltu;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    // EX/MEM registers, loaded every cycle regardless of in_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q   <= '0;
            branch_taken_q <= 1'b0;
            out_valid      <= 1'b0;
        end else begin
            alu_result_q   <= alu_result;
            branch_taken_q <= branch_taken;
            out_valid      <= in_valid;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Hand-computed vectors, immediate assertions.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] alu_result_q;
    logic        branch_taken_q;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] BAD = 7'b1111111;
    localparam logic [6:0] ALT = 7'b0100000;

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .operand1       (operand1),
        .operand2       (operand2),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .alu_result     (alu_result),
        .branch_taken   (branch_taken),
        .alu_result_q   (alu_result_q),
        .branch_taken_q (branch_taken_q),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    // Drive one vector, check combinational then registered outputs
    task automatic step(
        input string       tag,
        input logic        v,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [6:0]  opc,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] exp_res,
        input logic        exp_br
    );
        @(negedge clk);
        in_valid = v;
        operand1 = a;
        operand2 = b;
        opcode   = opc;
        funct3   = f3;
        funct7   = f7;
        #1;
        check({tag, " res"}, alu_result, exp_res);
        check({tag, " br"}, {31'd0, branch_taken}, {31'd0, exp_br});
        @(posedge clk);
        #1;
        check({tag, " res_q"}, alu_result_q, exp_res);
        check({tag, " br_q"}, {31'd0, branch_taken_q},
              {31'd0, exp_br});
        check({tag, " vld"}, {31'd0, out_valid}, {31'd0, v});
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst res_q", alu_result_q, 32'h0);
        check("rst br_q", {31'd0, branch_taken_q}, 32'h0);
        check("rst vld", {31'd0, out_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        step("add", 1, 32'd10, 32'd20, R, 3'b000, 7'd0,
             32'h0000001E, 0);
        step("sub", 1, 32'd30, 32'd15, R, 3'b000, ALT,
             32'h0000000F, 0);
        step("sub wrap", 1, 32'd0, 32'd1, R, 3'b000, ALT,
             32'hFFFFFFFF, 0);
        step("and", 1, 32'hFF00FF00, 32'h0F0F0F0F, R, 3'b111,
             7'd0, 32'h0F000F00, 0);
        step("or", 1, 32'hFF00FF00, 32'h0F0F0F0F, R, 3'b110,
             7'd0, 32'hFF0FFF0F, 0);
        step("xor", 1, 32'hFF00FF00, 32'h0F0F0F0F, R, 3'b100,
             7'd0, 32'hF00FF00F, 0);
        step("sra", 1, 32'h80000000, 32'd4, R, 3'b101, ALT,
             32'hF8000000, 0);
        step("srl", 1, 32'h80000000, 32'd4, R, 3'b101, 7'd0,
             32'h08000000, 0);
        step("sll 0x24", 1, 32'd1, 32'h24, R, 3'b001, 7'd0,
             32'h00000010, 0);
        step("slt", 1, 32'hFFFFFFFF, 32'd1, R, 3'b010, 7'd0,
             32'd1, 0);
        step("sltu", 1, 32'hFFFFFFFF, 32'd1, R, 3'b011, 7'd0,
             32'd0, 0);
        step("addi alt", 1, 32'd5, 32'd3, IMM, 3'b000, ALT,
             32'd8, 0);
        step("srai", 1, 32'h80000000, 32'd1, IMM, 3'b101, ALT,
             32'hC0000000, 0);
        step("srli", 1, 32'h80000000, 32'd1, IMM, 3'b101, 7'd0,
             32'h40000000, 0);
        step("blt", 1, 32'hFFFFFFFB, 32'd3, BR, 3'b100, 7'd0,
             32'hFFFFFFF8, 1);
        step("bgeu", 1, 32'd1, 32'hFFFFFFFF, BR, 3'b111, 7'd0,
             32'd2, 0);
        step("beq", 1, 32'd5, 32'd5, BR, 3'b000, 7'd0,
             32'd0, 1);
        step("bne", 1, 32'd5, 32'd5, BR, 3'b001, 7'd0,
             32'd0, 0);
        step("bge", 1, 32'd3, 32'hFFFFFFFB, BR, 3'b101, 7'd0,
             32'd8, 1);
        step("bltu", 1, 32'd3, 32'hFFFFFFFB, BR, 3'b110, 7'd0,
             32'd8, 1);
        step("br f3 010", 1, 32'd7, 32'd3, BR, 3'b010, 7'd0,
             32'd4, 0);
        step("lui", 1, 32'hDEAD0000, 32'h12345000, LUI, 3'b000,
             7'd0, 32'h12345000, 0);
        step("jal", 1, 32'h100, 32'h40, JAL, 3'b000, 7'd0,
             32'h104, 0);
        step("jalr", 1, 32'h200, 32'h40, JLR, 3'b000, 7'd0,
             32'h204, 0);
        step("auipc", 1, 32'h1000, 32'h20, AUI, 3'b000, 7'd0,
             32'h1020, 0);
        step("load", 1, 32'h1000, 32'hFFFFFFFC, LD, 3'b010, ALT,
             32'h0FFC, 0);
        step("store", 1, 32'h2000, 32'h8, ST, 3'b010, 7'd0,
             32'h2008, 0);
        step("unknown", 1, 32'd5, 32'd5, BAD, 3'b000, 7'd0,
             32'd0, 0);
        step("no valid", 0, 32'd1, 32'd2, R, 3'b000, 7'd0,
             32'd3, 0);

        // Reset asserted mid-stream, between clock edges
        step("pre rst", 1, 32'hFFFFFFFB, 32'd3, BR, 3'b100,
             7'd0, 32'hFFFFFFF8, 1);
        #2 rst = 1'b1;
        #1;
        check("async res_q", alu_result_q, 32'h0);
        check("async br_q", {31'd0, branch_taken_q}, 32'h0);
        check("async vld", {31'd0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("hold res_q", alu_result_q, 32'h0);
        check("hold vld", {31'd0, out_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel res_q", alu_result_q, 32'h0);
        check("rel vld", {31'd0, out_valid}, 32'h0);
        step("post rst", 1, 32'd10, 32'd20, R, 3'b000, 7'd0,
             32'h1E, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
